down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Loadable down-counter/timer; the count-down counterpart to the team's enable-driven up-counter.
- Counts from a loaded value toward zero on enabled ticks.
- Emits a one-cycle Pulse at terminal count, then either stops (one-shot) or auto-reloads (periodic).
- Used as a rate divider / event timer that feeds the up-counter's Enable and display logic.

Parameters:
- WIDTH, 8, width of LoadValue, CounterValue and the internal reload register.
- PRESCALE, 3, enabled cycles per tick minus one. Used only when DOWN_TIMER_PRESCALE_EN is defined; legal range 0..255.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  reset, asynchronous, active-low.
- Load  input  1  load LoadValue into counter and reload register.
- LoadValue  input  WIDTH  value to load; 0 means "do not run".
- Enable  input  1  tick enable; counting happens only while high.
- Periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot.
- CounterValue  output  WIDTH  current count (registered).
- Pulse  output  1  one-cycle terminal-count strobe (registered).
- Busy  output  1  high while state is RUN.

Behaviour:
- Clock and reset: one clock domain. Resetn low forces, asynchronously: state IDLE, CounterValue=0, reload=0, Pulse=0, Busy=0, prescaler=0.
- States: IDLE, RUN. Busy = (state==RUN), registered with the state.
- Priority each edge: Resetn > Load > tick > hold.
- Load=1:
  - reload<=LoadValue, CounterValue<=LoadValue, Pulse<=0, prescaler<=0.
  - State <= RUN if LoadValue!=0, else IDLE.
  - Applies in any state; Enable is ignored that cycle (no decrement).
- tick: equals Enable when the macro is undefined (see Optional Feature when defined). Evaluated only in RUN; in IDLE, Enable has no effect and CounterValue holds.
- RUN, tick, CounterValue>1: CounterValue<=CounterValue-1, Pulse<=0.
- RUN, tick, CounterValue==1 (terminal tick):
  - Pulse<=1.
  - Periodic=1: CounterValue<=reload, stay RUN.
  - Periodic=0: CounterValue<=0, state<=IDLE.
  - Periodic is sampled only on the terminal tick.
- RUN, no tick: all registers hold, Pulse<=0.
- Timing:
  - Loaded N≥1 with Enable held high: Pulse high exactly one cycle, on the Nth edge after the load edge.
  - Periodic mode: period = N ticks; Pulse never high two consecutive cycles unless N=1.
  - N=1 periodic with Enable held high: Pulse high every cycle, CounterValue constant at 1.
- Load coinciding with a terminal tick: Load wins, Pulse=0.
- Resetn asserted mid-run: immediate abort, no Pulse; reload cleared, so a new Load is required.
- Arithmetic: unsigned. CounterValue never wraps below 0; the value 0 is reachable only via one-shot completion, reset, or Load of 0.

Optional Feature:
- Macro: DOWN_TIMER_PRESCALE_EN.
- Defined:
  - An 8-bit prescaler counts Enable-high cycles 0..PRESCALE.
  - tick = Enable && (prescaler==PRESCALE); the prescaler wraps to 0 on that tick.
  - The prescaler holds when Enable=0, clears on Load, on reset and on entry to IDLE, and runs only in RUN.
  - Effective period = N*(PRESCALE+1) enabled cycles.
- Undefined: no prescaler register; tick = Enable; PRESCALE is ignored.

Test Plan:
- Reset: Resetn low asynchronously mid-cycle while RUN at count 5 -> CounterValue=0, Pulse=0, Busy=0 immediately, before the next edge. After release, Enable=1 -> count stays 0.
- One-shot: Load LoadValue=4, Periodic=0, Enable=1 continuously -> CounterValue 4,3,2,1,0; Pulse high only on the edge where the count goes 1->0; Busy drops on that same edge; afterwards Pulse stays 0.
- Periodic with Enable gaps: LoadValue=3, Periodic=1, Enable toggling 1,0,1,1,0,1,... -> count decrements only on Enable-high cycles, sequence 3,2,1,3,2,1; Pulse once per 3 enabled cycles.
- Boundary cases:
  - Load LoadValue=0 -> IDLE, Busy=0, no Pulse.
  - Load LoadValue=1 periodic with Enable=1 -> Pulse high every cycle.
  - Load LoadValue=255 -> 255 enabled cycles to first Pulse.
- Simultaneous events:
  - Load=1 with LoadValue=7 on a terminal-tick cycle -> CounterValue=7, Pulse=0.
  - Periodic switched 1->0 mid-run -> the next terminal tick stops at 0.
- Macro defined, PRESCALE=3: Load 2, Enable=1 continuously -> CounterValue changes every 4 cycles; Pulse on cycle 8 after load. Load mid-prescale -> prescaler restarts at 0.

Source files
------------

// File: rtl/down_timer.sv
// down_timer: loadable down-counter emitting a one-cycle Pulse at terminal count, one-shot or auto-reload.
// Optional tick prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 3
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Enable,
  input  logic             Periodic,
  output logic [WIDTH-1:0] CounterValue,
  output logic             Pulse,
  output logic             Busy
);
  typedef enum logic {IDLE, RUN} state_e;
  if (PRESCALE < 0 || PRESCALE > 255) begin : g_bad_prescale
    $error("down_timer: PRESCALE out of range 0..255");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic             pulse_q, pulse_d, busy_q, busy_d, tick;
`ifdef DOWN_TIMER_PRESCALE_EN
  localparam logic [7:0] PRE_MAX = 8'(PRESCALE);
  logic [7:0] pre_q, pre_d;
  assign tick = Enable && (pre_q == PRE_MAX);
`else
  assign tick = Enable;
`endif
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pulse_d  = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
    pre_d    = pre_q;
`endif
    if (Load) begin
      reload_d = LoadValue;
      count_d  = LoadValue;
      state_d  = (LoadValue != '0) ? RUN : IDLE;
`ifdef DOWN_TIMER_PRESCALE_EN
      pre_d    = 8'd0;
`endif
    end else if (state_q == RUN) begin
`ifdef DOWN_TIMER_PRESCALE_EN
      pre_d = Enable ? (tick ? 8'd0 : pre_q + 8'd1) : pre_q;
`endif
      if (tick) begin
        // count is never 0 in RUN, so 1 is the only terminal value
        pulse_d = (count_q == WIDTH'(1));
        count_d = pulse_d ? (Periodic ? reload_q : '0) : count_q - WIDTH'(1);
        state_d = (pulse_d && !Periodic) ? IDLE : RUN;
      end
    end
    busy_d = (state_d == RUN);
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
      pre_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
`ifdef DOWN_TIMER_PRESCALE_EN
      pre_q    <= pre_d;
`endif
    end
  end
  assign CounterValue = count_q;
  assign Pulse        = pulse_q;
  assign Busy         = busy_q;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed self-checking bench for down_timer.
module tb_down_timer;
  logic       Clock = 1'b0, Resetn = 1'b0, Load = 1'b0, Enable = 1'b0, Periodic = 1'b0;
  logic [7:0] LoadValue = 8'd0, CounterValue;
  logic       Pulse, Busy;
  int total = 0, bad = 0;

  down_timer #(.WIDTH(8), .PRESCALE(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .Load(Load), .LoadValue(LoadValue), .Enable(Enable),
    .Periodic(Periodic), .CounterValue(CounterValue), .Pulse(Pulse), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect3(input string tag, input int cv, input int p, input int b);
    chk({tag, "_cv"}, int'(CounterValue), cv);
    chk({tag, "_pulse"}, int'(Pulse), p);
    chk({tag, "_busy"}, int'(Busy), b);
  endtask

  task automatic do_load(input int v, input logic per, input logic en);
    Load = 1'b1; LoadValue = 8'(v); Periodic = per; Enable = en;
    step();
    Load = 1'b0;
  endtask

  initial begin
    int os_cv[5] = '{3, 2, 1, 0, 0};
    int os_p[5]  = '{0, 0, 0, 1, 0};
    int os_b[5]  = '{1, 1, 1, 0, 0};
    logic pe_en[8] = '{1, 0, 1, 1, 0, 1, 1, 1};
    int pe_cv[8]   = '{2, 2, 1, 3, 3, 2, 1, 3};
    int pe_p[8]    = '{0, 0, 0, 1, 0, 0, 0, 1};
    #12;
    expect3("reset", 0, 0, 0);
    Resetn = 1'b1;
    step();
    // one-shot countdown from 4
    do_load(4, 1'b0, 1'b1);
    expect3("os_load", 4, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect3($sformatf("os%0d", i), os_cv[i], os_p[i], os_b[i]);
    end
    // idle ignores Enable
    step();
    chk("idle_hold", int'(CounterValue), 0);
    // periodic with enable gaps
    do_load(3, 1'b1, 1'b0);
    expect3("pe_load", 3, 0, 1);
    for (int i = 0; i < 8; i++) begin
      Enable = pe_en[i];
      step();
      expect3($sformatf("pe%0d", i), pe_cv[i], pe_p[i], 1);
    end
    // async reset mid-run at count 5
    do_load(5, 1'b0, 1'b0);
    chk("rst_pre_cv", int'(CounterValue), 5);
    #2 Resetn = 1'b0;
    #1;
    expect3("rst_async", 0, 0, 0);
    #3 Resetn = 1'b1;
    Enable = 1'b1;
    step();
    step();
    expect3("rst_after", 0, 0, 0);
    // load of zero stays idle
    do_load(0, 1'b1, 1'b1);
    expect3("load0", 0, 0, 0);
    step();
    expect3("load0_run", 0, 0, 0);
    // N=1 periodic pulses every cycle
    do_load(1, 1'b1, 1'b1);
    expect3("n1_load", 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect3($sformatf("n1_%0d", i), 1, 1, 1);
    end
    // 255 cycles to first pulse
    do_load(255, 1'b0, 1'b1);
    expect3("n255_load", 255, 0, 1);
    for (int i = 1; i < 255; i++) begin
      step();
      chk($sformatf("n255_p%0d", i), int'(Pulse), 0);
    end
    chk("n255_cv254", int'(CounterValue), 1);
    step();
    expect3("n255_term", 0, 1, 0);
    // load wins over terminal tick
    do_load(2, 1'b1, 1'b1);
    step();
    chk("lt_cv1", int'(CounterValue), 1);
    do_load(7, 1'b1, 1'b1);
    expect3("lt_load7", 7, 0, 1);
    // periodic switched off mid-run
    do_load(2, 1'b1, 1'b1);
    step();
    step();
    expect3("sw_reload", 2, 1, 1);
    Periodic = 1'b0;
    step();
    expect3("sw_dec", 1, 0, 1);
    step();
    expect3("sw_stop", 0, 1, 0);
    step();
    expect3("sw_after", 0, 0, 0);
`ifdef DOWN_TIMER_PRESCALE_EN
    begin
      int ps_cv[8] = '{2, 2, 2, 1, 1, 1, 1, 0};
      do_load(2, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
        step();
        expect3($sformatf("ps%0d", i), ps_cv[i], (i == 7) ? 1 : 0, (i == 7) ? 0 : 1);
      end
      do_load(3, 1'b0, 1'b1);
      step();
      step();
      do_load(3, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        step();
        chk($sformatf("psr_hold%0d", i), int'(CounterValue), 3);
      end
      step();
      chk("psr_dec", int'(CounterValue), 2);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
